// File: rtl/wb_clint.sv
// wb_clint: Wishbone CLINT slave (msip, mtimecmp, mtime) driving xint_mtip_o/xint_msip_o, one-cycle ack/err
module wb_clint #(
  parameter int PRESCALER = 1,
  parameter int OFFSET_BITS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);
  localparam int PW = PRESCALER > 1 ? $clog2(PRESCALER) : 1;
  logic [PW-1:0] pre;
  logic [63:0] mtime, mtimecmp;
  logic msip;
  logic [OFFSET_BITS-1:0] off;
  logic req, hit, wr, tick;
  logic s_msip, s_cmp_lo, s_cmp_hi, s_mt_lo, s_mt_hi;
  logic [31:0] rdata;
  logic unused;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = s[i] ? n[8*i+:8] : o[8*i+:8];
    return r;
  endfunction
  assign off = wbs_addr_i[OFFSET_BITS-1:0];
  assign unused = ^wbs_addr_i[31:OFFSET_BITS];
  assign s_msip = off == OFFSET_BITS'(16'h0000);
  assign s_cmp_lo = off == OFFSET_BITS'(16'h4000);
  assign s_cmp_hi = off == OFFSET_BITS'(16'h4004);
  assign s_mt_lo = off == OFFSET_BITS'(16'hBFF8);
  assign s_mt_hi = off == OFFSET_BITS'(16'hBFFC);
  assign hit = (off[1:0] == 2'b00) & (s_msip | s_cmp_lo | s_cmp_hi | s_mt_lo | s_mt_hi);
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign wr = req & hit & wbs_we_i;
  assign tick = pre == PW'(PRESCALER - 1);
  always_comb begin
    rdata = s_msip ? {31'b0, msip} :
            s_cmp_lo ? mtimecmp[31:0] :
            s_cmp_hi ? mtimecmp[63:32] :
            s_mt_lo ? mtime[31:0] :
            s_mt_hi ? mtime[63:32] : 32'b0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      xint_mtip_o <= 1'b0;
      pre <= '0;
      mtime <= '0;
      mtimecmp <= '1;
      msip <= 1'b0;
    end else begin
      wbs_ack_o <= req & hit;
      wbs_err_o <= req & ~hit;
      if (req) wbs_dat_o <= hit ? rdata : '0;
      pre <= tick ? '0 : pre + PW'(1);
      if (wr & s_mt_lo) mtime[31:0] <= merge(mtime[31:0], wbs_dat_i, wbs_sel_i);
      else if (wr & s_mt_hi) mtime[63:32] <= merge(mtime[63:32], wbs_dat_i, wbs_sel_i);
      else if (tick) mtime <= mtime + 64'd1;
      if (wr & s_cmp_lo) mtimecmp[31:0] <= merge(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
      if (wr & s_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
      if (wr & s_msip & wbs_sel_i[0]) msip <= wbs_dat_i[0];
      xint_mtip_o <= mtime >= mtimecmp;
    end
  end
  assign xint_msip_o = msip;
endmodule

// File: tb/tb_wb_clint.sv
// tb_wb_clint: directed self-checking bench for wb_clint with PRESCALER 1 and 4 instances
module tb_wb_clint;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] addr = '0, dat = '0;
  logic [31:0] dat1, dat4;
  logic ack1, err1, mtip1, msip1, ack4, err4, mtip4, msip4;
  logic r_ack, r_err, r_ack4, r_mtip;
  logic [31:0] r_dat, r_dat4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  wb_clint #(.PRESCALER(1), .OFFSET_BITS(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_addr_i(addr), .wbs_dat_i(dat), .wbs_dat_o(dat1),
    .wbs_ack_o(ack1), .wbs_err_o(err1), .xint_mtip_o(mtip1), .xint_msip_o(msip1)
  );
  wb_clint #(.PRESCALER(4), .OFFSET_BITS(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_addr_i(addr), .wbs_dat_i(dat), .wbs_dat_o(dat4),
    .wbs_ack_o(ack4), .wbs_err_o(err4), .xint_mtip_o(mtip4), .xint_msip_o(msip4)
  );
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat = d; sel = s;
    @(posedge clk); #1;
    r_ack = ack1; r_err = err1; r_dat = dat1; r_ack4 = ack4; r_dat4 = dat4; r_mtip = mtip1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (ack1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL rst_resp: ack=%b err=%b exp 0 0", ack1, err1); end
    checks++; if (mtip1 !== 1'b0 || msip1 !== 1'b0) begin errors++; $display("FAIL rst_irq: mtip=%b msip=%b exp 0 0", mtip1, msip1); end
    checks++; if (dat1 !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h exp 00000000", dat1); end
    xfer(1'b0, 32'h4000, 32'h0, 4'hF);
    checks++; if (r_ack !== 1'b1 || r_err !== 1'b0 || r_ack4 !== 1'b1) begin errors++; $display("FAIL rst_ack: ack=%b err=%b ack4=%b exp 1 0 1", r_ack, r_err, r_ack4); end
    checks++; if (r_dat !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_cmp_lo: got %h exp FFFFFFFF", r_dat); end
    xfer(1'b0, 32'h4004, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'hFFFFFFFF || r_dat4 !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_cmp_hi: got %h/%h exp FFFFFFFF", r_dat, r_dat4); end
    checks++; if (mtip1 !== 1'b0 || msip1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL rst_idle: mtip=%b msip=%b err=%b exp 0 0 0", mtip1, msip1, err1); end
  endtask
  task automatic test_msip();
    xfer(1'b1, 32'h0000, 32'h1, 4'h1);
    checks++; if (r_ack !== 1'b1) begin errors++; $display("FAIL msip_wr_ack: got %b exp 1", r_ack); end
    checks++; if (msip1 !== 1'b1 || msip4 !== 1'b1) begin errors++; $display("FAIL msip_set: got %b/%b exp 1", msip1, msip4); end
    xfer(1'b0, 32'h0000, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'h1) begin errors++; $display("FAIL msip_rd1: got %h exp 00000001", r_dat); end
    xfer(1'b1, 32'h0000, 32'hFFFFFFFE, 4'hF);
    checks++; if (msip1 !== 1'b0) begin errors++; $display("FAIL msip_clr: got %b exp 0", msip1); end
    xfer(1'b0, 32'h0000, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'h0) begin errors++; $display("FAIL msip_rd0: got %h exp 00000000", r_dat); end
  endtask
  task automatic test_mtip();
    xfer(1'b1, 32'hBFF8, 32'h0, 4'hF);
    xfer(1'b1, 32'h4004, 32'h0, 4'hF);
    xfer(1'b1, 32'h4000, 32'd20, 4'hF);
    repeat (15) @(posedge clk);
    #1;
    checks++; if (mtip1 !== 1'b0) begin errors++; $display("FAIL mtip_early: got %b exp 0", mtip1); end
    @(posedge clk); #1;
    checks++; if (mtip1 !== 1'b1) begin errors++; $display("FAIL mtip_rise: got %b exp 1", mtip1); end
    xfer(1'b1, 32'h4004, 32'hFFFFFFFF, 4'hF);
    checks++; if (r_mtip !== 1'b1) begin errors++; $display("FAIL mtip_at_ack: got %b exp 1", r_mtip); end
    checks++; if (mtip1 !== 1'b0) begin errors++; $display("FAIL mtip_fall: got %b exp 0", mtip1); end
  endtask
  task automatic test_carry();
    xfer(1'b1, 32'hBFFC, 32'h0, 4'hF);
    xfer(1'b1, 32'hBFF8, 32'hFFFFFFFF, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    xfer(1'b0, 32'hBFFC, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'h1 || r_dat4 !== 32'h1) begin errors++; $display("FAIL carry_hi: got %h/%h exp 00000001", r_dat, r_dat4); end
    xfer(1'b0, 32'hBFF8, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'd8) begin errors++; $display("FAIL carry_lo: got %h exp 00000008", r_dat); end
    checks++; if (r_dat4 < 32'd1 || r_dat4 > 32'd2) begin errors++; $display("FAIL carry_lo4: got %h exp 1..2", r_dat4); end
  endtask
  task automatic test_prescale();
    logic [31:0] a1 [5];
    logic [31:0] a4 [5];
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, 32'hBFF8, 32'h0, 4'hF);
      a1[i] = r_dat; a4[i] = r_dat4;
    end
    checks++; if (a1[1] - a1[0] !== 32'd2) begin errors++; $display("FAIL pre1_step: got %0d exp 2", a1[1] - a1[0]); end
    checks++; if (a4[2] - a4[0] !== 32'd1) begin errors++; $display("FAIL pre4_step4: got %0d exp 1", a4[2] - a4[0]); end
    checks++; if (a4[4] - a4[0] !== 32'd2) begin errors++; $display("FAIL pre4_step8: got %0d exp 2", a4[4] - a4[0]); end
  endtask
  task automatic test_errors();
    xfer(1'b0, 32'h0010, 32'h0, 4'hF);
    checks++; if (r_err !== 1'b1 || r_ack !== 1'b0 || r_dat !== 32'h0) begin errors++; $display("FAIL err_0010: err=%b ack=%b dat=%h exp 1 0 00000000", r_err, r_ack, r_dat); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b exp 0", err1); end
    xfer(1'b0, 32'h4002, 32'h0, 4'hF);
    checks++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin errors++; $display("FAIL err_4002: err=%b ack=%b exp 1 0", r_err, r_ack); end
    xfer(1'b1, 32'h8000, 32'h12345678, 4'hF);
    checks++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin errors++; $display("FAIL err_8000: err=%b ack=%b exp 1 0", r_err, r_ack); end
    xfer(1'b1, 32'h4001, 32'h0, 4'hF);
    xfer(1'b1, 32'h0004, 32'h1, 4'hF);
    xfer(1'b0, 32'h4000, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'd20) begin errors++; $display("FAIL err_keep_cmp_lo: got %h exp 00000014", r_dat); end
    xfer(1'b0, 32'h4004, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'hFFFFFFFF) begin errors++; $display("FAIL err_keep_cmp_hi: got %h exp FFFFFFFF", r_dat); end
    checks++; if (msip1 !== 1'b0) begin errors++; $display("FAIL err_keep_msip: got %b exp 0", msip1); end
  endtask
  task automatic test_byte_lanes();
    do_reset();
    xfer(1'b1, 32'h4000, 32'h0000AB00, 4'b0010);
    xfer(1'b0, 32'h4000, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'hFFFFABFF) begin errors++; $display("FAIL sel_cmp_lo: got %h exp FFFFABFF", r_dat); end
    xfer(1'b1, 32'h4004, 32'h12000000, 4'b1000);
    xfer(1'b0, 32'h4004, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'h12FFFFFF) begin errors++; $display("FAIL sel_cmp_hi: got %h exp 12FFFFFF", r_dat); end
    xfer(1'b1, 32'h0000, 32'h1, 4'h0);
    checks++; if (r_ack !== 1'b1 || msip1 !== 1'b0) begin errors++; $display("FAIL sel_none: ack=%b msip=%b exp 1 0", r_ack, msip1); end
  endtask
  task automatic test_back_to_back();
    logic [5:0] pat;
    pat = 6'b101010;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h4000; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      checks++; if (ack1 !== pat[i]) begin errors++; $display("FAIL b2b_ack%0d: got %b exp %b", i, ack1, pat[i]); end
      if (i == 3) begin
        checks++; if (dat1 !== 32'hFFFFABFF) begin errors++; $display("FAIL b2b_dat: got %h exp FFFFABFF", dat1); end
      end
      @(posedge clk); #1;
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_dropped();
    cyc = 1'b1; stb = 1'b0; we = 1'b1; addr = 32'h4000; dat = 32'h0; sel = 4'hF;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL drop_stb: ack=%b err=%b exp 0 0", ack1, err1); end
    cyc = 1'b0; stb = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL drop_cyc: got %b exp 0", ack1); end
    stb = 1'b0; we = 1'b0;
    xfer(1'b0, 32'h4000, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'hFFFFABFF) begin errors++; $display("FAIL drop_keep: got %h exp FFFFABFF", r_dat); end
  endtask
  task automatic test_reset_mid();
    xfer(1'b1, 32'h0000, 32'h1, 4'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h4000; dat = 32'h0; sel = 4'hF; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL rstmid_resp: ack=%b err=%b exp 0 0", ack1, err1); end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    checks++; if (msip1 !== 1'b0) begin errors++; $display("FAIL rstmid_msip: got %b exp 0", msip1); end
    xfer(1'b0, 32'h4000, 32'h0, 4'hF);
    checks++; if (r_dat !== 32'hFFFFFFFF) begin errors++; $display("FAIL rstmid_cmp: got %h exp FFFFFFFF", r_dat); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_msip();
    test_mtip();
    test_carry();
    test_prescale();
    test_errors();
    test_byte_lanes();
    test_back_to_back();
    test_dropped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
